// File: rtl/csa2_64bit.sv
// csa2_64bit: registered 64-bit carry-select adder.
// The core is split into BLOCK_W-bit blocks. Each block above block 0
// precomputes its sum for carry-in 0 and for carry-in 1 using two ripple
// chains, and the carry from the block below picks one of the two results.
// {c_out, sum} is registered once, which gives one cycle of latency.

// Single full adder cell: s = x^y^ci, co = xy | ci(x^y).
module csa2_fa (
    input  logic x_i,
    input  logic y_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    logic p;

    // Propagate term, shared by the sum and the carry.
    always_comb begin
        p    = x_i ^ y_i;
        s_o  = p ^ ci_i;
        co_o = (x_i & y_i) | (ci_i & p);
    end
endmodule

// W-bit ripple-carry adder built from a chain of full adders.
module csa2_rca #(
    parameter int W = 8
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         ci_i,
    output logic [W-1:0] s_o,
    output logic         co_o
);
    // chain[i] is the carry into bit i; chain[W] is the carry out.
    logic [W:0] chain;

    assign chain[0] = ci_i;

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        csa2_fa u_fa (
            .x_i  (x_i[gi]),
            .y_i  (y_i[gi]),
            .ci_i (chain[gi]),
            .s_o  (s_o[gi]),
            .co_o (chain[gi+1])
        );
    end

    assign co_o = chain[W];
endmodule

// Top: carry-select core followed by the output register.
module csa2_64bit #(
    parameter int BLOCK_W = 8    // 4, 8 or 16; must divide 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        c_in,
    output logic [63:0] sum,
    output logic        c_out
);
    localparam int NBLK = 64 / BLOCK_W;

    // blk_c[k] is the selected carry into block k; blk_c[NBLK] is c_out.
    logic [NBLK:0] blk_c;
    logic [63:0]   core_sum;

    logic [63:0]   sum_q;
    logic [63:0]   sum_d;
    logic          c_out_q;
    logic          c_out_d;

    assign blk_c[0] = c_in;

    for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
        if (gi == 0) begin : g_first
            // The lowest block sees the real carry-in directly.
            csa2_rca #(.W(BLOCK_W)) u_rca (
                .x_i  (a[BLOCK_W-1:0]),
                .y_i  (b[BLOCK_W-1:0]),
                .ci_i (c_in),
                .s_o  (core_sum[BLOCK_W-1:0]),
                .co_o (blk_c[1])
            );
        end else begin : g_sel
            logic [BLOCK_W-1:0] s0;
            logic [BLOCK_W-1:0] s1;
            logic               co0;
            logic               co1;

            // Speculative chain assuming no carry into this block.
            csa2_rca #(.W(BLOCK_W)) u_rca0 (
                .x_i  (a[gi*BLOCK_W +: BLOCK_W]),
                .y_i  (b[gi*BLOCK_W +: BLOCK_W]),
                .ci_i (1'b0),
                .s_o  (s0),
                .co_o (co0)
            );

            // Speculative chain assuming a carry into this block.
            csa2_rca #(.W(BLOCK_W)) u_rca1 (
                .x_i  (a[gi*BLOCK_W +: BLOCK_W]),
                .y_i  (b[gi*BLOCK_W +: BLOCK_W]),
                .ci_i (1'b1),
                .s_o  (s1),
                .co_o (co1)
            );

            // The carry selected for the block below picks the real result.
            always_comb begin
                core_sum[gi*BLOCK_W +: BLOCK_W] = blk_c[gi] ? s1 : s0;
                blk_c[gi+1]                     = blk_c[gi] ? co1 : co0;
            end
        end
    end

    // Next-state for the output register is simply the core result.
    always_comb begin
        sum_d   = core_sum;
        c_out_d = blk_c[NBLK];
    end

    // Output register; reset clears it immediately, without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= 64'h0;
            c_out_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
endmodule

// File: tb/tb_csa2_64bit.sv
// Testbench for csa2_64bit: directed vectors, asynchronous reset behaviour
// and back-to-back random vectors against a 65-bit reference sum.
module tb_csa2_64bit;
    logic        clk;
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
    logic        c_in;
    logic [63:0] sum;
    logic        c_out;

    int total;
    int bad;

    csa2_64bit #(.BLOCK_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand set before an edge, then wait just past that edge.
    task automatic drive_one(input logic [63:0] av, input logic [63:0] bv, input logic cv);
        @(negedge clk);
        a    = av;
        b    = bv;
        c_in = cv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        a    = 64'h1234;
        b    = 64'h1;
        c_in = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (sum !== 64'h0 || c_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got c_out=%b sum=%h, want c_out=0 sum=0", c_out, sum);
        end
        $display("reset_state: c_out=%b sum=%h", c_out, sum);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [63:0] va   [5];
        logic [63:0] vb   [5];
        logic        vc   [5];
        logic [63:0] esum [5];
        logic        eco  [5];
        va[0] = 64'h3;                 vb[0] = 64'h5;                 vc[0] = 1'b0; esum[0] = 64'h8;                 eco[0] = 1'b0;
        va[1] = 64'h3;                 vb[1] = 64'h5;                 vc[1] = 1'b1; esum[1] = 64'h9;                 eco[1] = 1'b0;
        va[2] = 64'hFFFF_FFFF_FFFF_FFFF; vb[2] = 64'hFFFF_FFFF_FFFF_FFFF; vc[2] = 1'b1; esum[2] = 64'hFFFF_FFFF_FFFF_FFFF; eco[2] = 1'b1;
        va[3] = 64'hFFFF_FFFF_FFFF_FFFF; vb[3] = 64'h1;                 vc[3] = 1'b0; esum[3] = 64'h0;                 eco[3] = 1'b1;
        va[4] = 64'hA;                 vb[4] = 64'hFFFF_FFFF_FFFF_FFF6; vc[4] = 1'b0; esum[4] = 64'h0;                 eco[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_one(va[i], vb[i], vc[i]);
            total++;
            if (sum !== esum[i] || c_out !== eco[i]) begin
                bad++;
                $display("FAIL directed_%0d: got c_out=%b sum=%h, want c_out=%b sum=%h",
                         i, c_out, sum, eco[i], esum[i]);
            end
            $display("directed_%0d: a=%h b=%h c_in=%b -> c_out=%b sum=%h",
                     i, va[i], vb[i], vc[i], c_out, sum);
        end
    endtask

    task automatic test_block_carry();
        // A carry generated in the top bit of one block must ripple through
        // every all-propagate block above it.
        drive_one(64'h0000_0000_0000_0080, 64'h7FFF_FFFF_FFFF_FF80, 1'b0);
        total++;
        if (sum !== 64'h8000_0000_0000_0000 || c_out !== 1'b0) begin
            bad++;
            $display("FAIL block_carry: got c_out=%b sum=%h, want c_out=0 sum=8000000000000000", c_out, sum);
        end
        $display("block_carry: c_out=%b sum=%h", c_out, sum);
    endtask

    task automatic test_async_reset();
        drive_one(64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
        total++;
        if (sum !== 64'h2020_3131_4242_5354 || c_out !== 1'b0) begin
            bad++;
            $display("FAIL preload: got c_out=%b sum=%h, want c_out=0 sum=2020313142425354", c_out, sum);
        end
        $display("preload: c_out=%b sum=%h", c_out, sum);
        // Assert reset between edges; the clear must not wait for clk.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (sum !== 64'h0 || c_out !== 1'b0) begin
            bad++;
            $display("FAIL async_clear: got c_out=%b sum=%h, want c_out=0 sum=0", c_out, sum);
        end
        $display("async_clear: c_out=%b sum=%h", c_out, sum);
        // Outputs hold at zero across edges while reset is high.
        a    = 64'hFFFF_FFFF_FFFF_FFFF;
        b    = 64'hFFFF_FFFF_FFFF_FFFF;
        c_in = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (sum !== 64'h0 || c_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: got c_out=%b sum=%h, want c_out=0 sum=0", c_out, sum);
        end
        $display("reset_hold: c_out=%b sum=%h", c_out, sum);
        // First edge after release loads the current inputs.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (sum !== 64'hFFFF_FFFF_FFFF_FFFF || c_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got c_out=%b sum=%h, want c_out=1 sum=ffffffffffffffff", c_out, sum);
        end
        $display("reset_release: c_out=%b sum=%h", c_out, sum);
    endtask

    task automatic test_back_to_back();
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;
        logic [64:0] exp_res;
        for (int i = 0; i < 16; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            if (i == 0) rb = ~ra;   // all-propagate pattern
            exp_res = {1'b0, ra} + {1'b0, rb} + {64'h0, rc};
            drive_one(ra, rb, rc);
            total++;
            if ({c_out, sum} !== exp_res) begin
                bad++;
                $display("FAIL random_%0d: got %h, want %h", i, {c_out, sum}, exp_res);
            end
            $display("random_%0d: a=%h b=%h c_in=%b -> %h", i, ra, rb, rc, {c_out, sum});
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        a     = 64'h0;
        b     = 64'h0;
        c_in  = 1'b0;
        test_reset();
        test_directed();
        test_block_carry();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csa2_64bit.md
# csa2_64bit

Registered 64-bit carry-select adder computing {c_out, sum} = a + b + c_in. The adder core is split into 8-bit blocks. Each block precomputes its result for both possible carry-ins with two ripple-carry chains, and the real carry selects between them. The block sits in the datapath as a drop-in wide adder with one cycle of latency. Its outputs are registered on the system clock and cleared by reset.

## Interface
- Parameters:
- BLOCK_W, default 8: bits per carry-select block. Must divide 64. Legal values: 4, 8, 16.
- Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high; clears all output registers
- a  input  64  addend A, unsigned
- b  input  64  addend B, unsigned
- c_in  input  1  carry into bit 0
- sum  output  64  registered a + b + c_in, bits [63:0]
- c_out  output  1  registered carry out of bit 63 (bit 64 of the full result)

## Operation
- Combinational core, block 0 (bits [BLOCK_W-1:0]): one ripple-carry adder fed directly by c_in.
- Combinational core, blocks k = 1 .. 64/BLOCK_W-1:
  - Two ripple-carry adders on the same a/b slice, one with carry-in 0 and one with carry-in 1.
  - A 2:1 mux picks the slice sum and block carry-out using the carry-out selected for block k-1.
- c_out is the selected carry-out of the top block.
- Each ripple adder is a chain of full adders: s = x^y^ci, co = xy | ci(x^y).
- Arithmetic is purely unsigned and modulo 2^65 for the pair {c_out, sum}. There is no overflow flag and no saturation.
- The result must equal a 65-bit reference sum for every input: {c_out, sum} = {1'b0,a} + {1'b0,b} + c_in.
- Full-width carry propagation must be correct, e.g. a = all-ones, b = 0, c_in = 1 gives sum = 0 and c_out = 1.
- On every rising clk edge with rst low, sum and c_out load the core result.

## Timing
- Latency is one clock cycle. Inputs are sampled at rising edge N; the result is visible on sum/c_out after edge N.
- No handshake. A new operation is accepted every cycle at full throughput.
- Inputs are not registered inside the block; they must be stable at the sampling edge.
- Reset value: sum = 64'h0, c_out = 0.
- Reset takes effect immediately on rst assertion, without waiting for clk.
- Reset mid-operation: a result in flight is discarded; outputs stay 0 while rst is high.
- Reset release: the first rising edge with rst low loads the current inputs.
- Critical path: BLOCK_W-bit ripple plus (64/BLOCK_W - 1) mux stages. This must close at the system clock period.

## Test plan
- a=64'h3, b=64'h5, c_in=0, one edge -> sum=64'h8, c_out=0.
- a=64'h3, b=64'h5, c_in=1 -> sum=64'h9, c_out=0.
- a=b=64'hFFFF_FFFF_FFFF_FFFF, c_in=1 -> sum=64'hFFFF_FFFF_FFFF_FFFF, c_out=1.
- a=64'hFFFF_FFFF_FFFF_FFFF, b=64'h1, c_in=0 -> sum=0, c_out=1 (full-chain carry across every block boundary).
- a=64'hA, b=64'hFFFF_FFFF_FFFF_FFF6, c_in=0 -> sum=0, c_out=1.
- Reset and random vectors:
  - Assert rst asynchronously between edges while outputs are nonzero -> sum=0 and c_out=0 immediately.
  - Then 12+ random {a, b, c_in} vectors, one per cycle -> each result equals the 65-bit reference sum one cycle later.
